// File: rtl/unidad_control.sv
// unidad_control: fetch/exec sequencer that issues datapath control words and resolves JMP/BRC/HALT.
module unidad_control #(
    parameter int N  = 4,
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [23:0]   imem_data,
    input  logic [3:0]    stateBits,
    output logic [PW-1:0] imem_addr,
    output logic [15:0]   ctrl_word,
    output logic [N-1:0]  constant_out,
    output logic          busy,
    output logic          halted
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
    state_t state;
    logic [23:0] ir;
    logic [PW-1:0] pc;
    logic [1:0] op;
    logic take;
    assign op           = ir[23:22];
    assign take         = op == 2'b01 || (op == 2'b10 && stateBits[ir[13:12]] == ir[14]);
    assign imem_addr    = pc;
    assign constant_out = ir[16+N-1:16];
    // ctrl_word is registered at the FETCH edge so it is live for exactly the EXEC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            ctrl_word <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= run ? FETCH : IDLE;
                    busy  <= run;
                end
                FETCH: begin
                    ir        <= imem_data;
                    pc        <= pc + 1'b1;
                    ctrl_word <= imem_data[23:22] == 2'b00 ? imem_data[15:0] : 16'h0000;
                    state     <= EXEC;
                end
                EXEC: begin
                    ctrl_word <= 16'h0000;
                    pc        <= take ? ir[16+PW-1:16] : pc;
                    state     <= op == 2'b11 ? HALT : FETCH;
                    busy      <= op != 2'b11;
                    halted    <= op == 2'b11;
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_unidad_control.sv
// tb_unidad_control: cycle-accurate scoreboard bench for unidad_control.
module tb_unidad_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic [23:0] imem_data;
    logic [3:0] state_bits = 4'b0000;
    logic [5:0] imem_addr;
    logic [15:0] ctrl_word;
    logic [3:0] constant_out;
    logic busy, halted;
    logic [23:0] mem [64];
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [5:0]  a;
        logic [15:0] cw;
        logic [3:0]  k;
        logic        b;
        logic        h;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    unidad_control #(.N(4), .PW(6)) dut (
        .clk(clk), .reset(reset), .run(run), .imem_data(imem_data),
        .stateBits(state_bits), .imem_addr(imem_addr), .ctrl_word(ctrl_word),
        .constant_out(constant_out), .busy(busy), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    // push the expected post-edge outputs, advance one clock, pop and compare
    task automatic step(input logic [5:0] a, input logic [15:0] cw, input logic [3:0] k,
                        input logic b, input logic h);
        exp_t e;
        q.push_back('{a, cw, k, b, h});
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("imem_addr", 32'(imem_addr), 32'(e.a));
        check("ctrl_word", 32'(ctrl_word), 32'(e.cw));
        check("constant_out", 32'(constant_out), 32'(e.k));
        check("busy", 32'(busy), 32'(e.b));
        check("halted", 32'(halted), 32'(e.h));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 24'h0;
        // reset then idle
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

        // program A: EXEC, BRC taken, EXEC, BRC not taken, HALT; run held high throughout
        mem[0] = 24'h030A5B;
        mem[1] = 24'h856000;
        mem[5] = 24'h021234;
        mem[6] = 24'h856000;
        mem[7] = 24'hC00000;
        run = 1'b1;
        step(0, 16'h0000, 0, 1, 0);
        step(1, 16'h0A5B, 3, 1, 0);
        step(1, 16'h0000, 3, 1, 0);
        state_bits = 4'b0100;
        step(2, 16'h0000, 5, 1, 0);
        step(5, 16'h0000, 5, 1, 0);
        step(6, 16'h1234, 2, 1, 0);
        state_bits = 4'b0000;
        step(6, 16'h0000, 2, 1, 0);
        step(7, 16'h0000, 5, 1, 0);
        step(7, 16'h0000, 5, 1, 0);
        step(8, 16'h0000, 0, 1, 0);
        step(8, 16'h0000, 0, 0, 1);
        step(8, 16'h0000, 0, 0, 1);
        run = 1'b0;
        step(8, 16'h0000, 0, 0, 1);

        // program B: JMP to 63, wrap to 0, reset during an EXEC cycle
        do_reset();
        for (int i = 0; i < 64; i++) mem[i] = 24'h0;
        mem[0]  = 24'h7F0000;
        mem[63] = 24'h0155AA;
        run = 1'b1;
        step(0, 16'h0000, 0, 1, 0);
        run = 1'b0;
        step(1, 16'h0000, 4'hF, 1, 0);
        step(63, 16'h0000, 4'hF, 1, 0);
        step(0, 16'h55AA, 1, 1, 0);
        step(0, 16'h0000, 1, 1, 0);
        step(1, 16'h0000, 4'hF, 1, 0);
        step(63, 16'h0000, 4'hF, 1, 0);
        step(0, 16'h55AA, 1, 1, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0);
        run = 1'b1;
        step(0, 16'h0000, 0, 1, 0);
        run = 1'b0;
        step(1, 16'h0000, 4'hF, 1, 0);

        // program C: HALT at address 2, run pulse ignored afterwards
        do_reset();
        mem[0] = 24'h000200;
        mem[1] = 24'h0FFFFF;
        mem[2] = 24'hC00000;
        run = 1'b1;
        step(0, 16'h0000, 0, 1, 0);
        run = 1'b0;
        step(1, 16'h0200, 0, 1, 0);
        step(1, 16'h0000, 0, 1, 0);
        step(2, 16'hFFFF, 4'hF, 1, 0);
        step(2, 16'h0000, 4'hF, 1, 0);
        step(3, 16'h0000, 0, 1, 0);
        step(3, 16'h0000, 0, 0, 1);
        run = 1'b1;
        step(3, 16'h0000, 0, 0, 1);
        run = 1'b0;
        step(3, 16'h0000, 0, 0, 1);
        step(3, 16'h0000, 0, 0, 1);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
